raycast_node_arbiter: RTL and testbench
=======================================

Name: raycast_node_arbiter

Overview:
- Shares one node-memory read port between N_CORES raycast_core instances.
- Accepts each core's node request (node_req/node_req_far/node_req_adr) and grants cores round-robin.
- Issues one memory read at a time and returns data plus address to all cores; acks the granted core and, optionally, every other core waiting on the same address.
- Sits between the core array and the node cache/memory controller.

Parameters:
N_CORES, 4, number of requesting cores (2..8)
ADR_W, 32, node address width
DATA_W, 32, node data width
COALESCE, 1, 1 = ack all pending cores whose address matches the returned address

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-low
core_req_i  in  N_CORES  per-core node_req_o
core_far_i  in  N_CORES  per-core node_req_far_o
core_adr_i  in  N_CORES*ADR_W  per-core node_req_adr_o; core k in bits [k*ADR_W +: ADR_W]
core_ack_o  out  N_CORES  per-core node_ack_i; one-cycle pulse
core_data_o  out  DATA_W  broadcast node_data_i
core_adr_o  out  ADR_W  broadcast node_adr_i
mem_req_o  out  1  memory read request
mem_far_o  out  1  far flag of the granted request
mem_adr_o  out  ADR_W  memory read address
mem_ack_i  in  1  memory read done; mem_data_i valid this cycle
mem_data_i  in  DATA_W  read data
grant_o  out  N_CORES  one-hot current grant, for debug; 0 when idle

Behaviour:
- Reset (rst low, async): all outputs 0, state IDLE, rr_ptr=0, ack_mask=0.
- Core handshake:
  - A core holds req, far and adr stable until it sees core_ack_o[k].
  - The core may keep req high for one cycle after the ack.
  - eligible[k] = core_req_i[k] & ~ack_mask[k].
  - ack_mask is a register holding the previous cycle's core_ack_o.
- FSM state IDLE:
  - If any core is eligible, pick the first eligible index at or after rr_ptr, wrapping modulo N_CORES.
  - Register grant, mem_adr_o=core_adr_i[g], mem_far_o=core_far_i[g], mem_req_o=1; go to ISSUE.
  - Latency: eligible request at edge t, mem_req_o high from edge t+1.
- FSM state ISSUE:
  - Hold mem_req_o, mem_adr_o and mem_far_o stable.
  - On mem_ack_i: drop mem_req_o and register core_data_o=mem_data_i, core_adr_o=mem_adr_o.
  - Same edge: core_ack_o[g]=1, plus core_ack_o[j]=1 for each j≠g with eligible[j] & core_adr_i[j]==mem_adr_o, when COALESCE=1.
  - Same edge: rr_ptr=(g+1) mod N_CORES; go to RESP.
  - mem_ack_i at edge u gives core_ack_o high for cycle u+1.
- FSM state RESP: one cycle; core_ack_o clears at the next edge; go to IDLE. No memory request is issued in RESP.
- Output timing:
  - core_data_o and core_adr_o hold their last value until the next response.
  - Cores qualify them only with their own ack.
- Minimum spacing: 3 cycles from one mem_req_o rising edge to the next (IDLE→ISSUE→RESP).
- mem_ack_i outside ISSUE is ignored.
- A core that drops req while granted (protocol violation): the transaction still completes and the ack is still pulsed; no recovery.
- Reset mid-ISSUE: mem_req_o drops asynchronously and the in-flight response is discarded. The memory side must also be reset.
- Arithmetic: rr_ptr width clog2(N_CORES); wrap from N_CORES-1 to 0.

Test Plan:
- Single request: core1 req adr=0x100, mem_ack 2 cycles after mem_req, data=0xDEADBEEF -> mem_adr_o=0x100 one cycle after req; core_ack_o=0010 for exactly one cycle; core_data_o=0xDEADBEEF, core_adr_o=0x100.
- Round-robin: cores 0, 2 and 3 request continuously, all at distinct addresses -> grant order 0,2,3,0,2,3; no core is granted twice before the others are served.
- Coalescing: cores 0 and 3 both request adr=0x40, COALESCE=1 -> one mem_req_o; core_ack_o=1001 in one cycle. With COALESCE=0 -> two sequential memory reads.
- Ack masking: core 2 holds req one cycle past its ack, no other requests -> no second grant to core 2; mem_req_o stays 0.
- Far flag: core 0 request with far=1 -> mem_far_o=1 for the whole ISSUE state.
- Reset mid-transaction: assert rst low during ISSUE with mem_req_o=1 -> mem_req_o, grant_o and core_ack_o are 0 immediately. After release, the first grant goes to the lowest eligible index (rr_ptr=0).

Source files
------------

// File: rtl/raycast_node_arbiter_if.sv
// Bus interfaces for raycast_node_arbiter: the per-core node request bus and
// the single memory read port shared by all cores.

// Handshake rules for both buses: a request (core_req_i[k] / mem_req_o) is
// raised with its address and far flag and holds all of them stable until the
// matching done pulse (core_ack_o[k] / mem_ack_i) is seen. Data returned with
// the done pulse is valid only in that cycle for the acked requester.
interface raycast_node_if #(
    parameter int N_CORES = 4,
    parameter int ADR_W   = 32,
    parameter int DATA_W  = 32
);
    logic [N_CORES-1:0]       core_req_i;
    logic [N_CORES-1:0]       core_far_i;
    logic [N_CORES*ADR_W-1:0] core_adr_i;
    logic [N_CORES-1:0]       core_ack_o;
    logic [DATA_W-1:0]        core_data_o;
    logic [ADR_W-1:0]         core_adr_o;

    modport master (
        output core_req_i, core_far_i, core_adr_i,
        input  core_ack_o, core_data_o, core_adr_o
    );

    modport slave (
        input  core_req_i, core_far_i, core_adr_i,
        output core_ack_o, core_data_o, core_adr_o
    );
endinterface

interface raycast_mem_if #(
    parameter int ADR_W  = 32,
    parameter int DATA_W = 32
);
    logic              mem_req_o;
    logic              mem_far_o;
    logic [ADR_W-1:0]  mem_adr_o;
    logic              mem_ack_i;
    logic [DATA_W-1:0] mem_data_i;

    modport master (
        output mem_req_o, mem_far_o, mem_adr_o,
        input  mem_ack_i, mem_data_i
    );

    modport slave (
        input  mem_req_o, mem_far_o, mem_adr_o,
        output mem_ack_i, mem_data_i
    );
endinterface

// File: rtl/raycast_node_arbiter.sv
// Round-robin arbiter sharing one node-memory read port among N_CORES raycast
// cores; broadcasts each read result and optionally acks every core waiting on it.
module raycast_node_arbiter #(
    parameter int N_CORES  = 4,
    parameter int ADR_W    = 32,
    parameter int DATA_W   = 32,
    parameter int COALESCE = 1
) (
    input  logic               clk,
    input  logic               rst,
    raycast_node_if.slave      node,
    raycast_mem_if.master      mem,
    output logic [N_CORES-1:0] grant_o,
    output logic [1:0]         state_o
);

    localparam int PTR_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   grant_idx_q, grant_idx_d;
    logic [N_CORES-1:0] grant_q, grant_d;
    logic [N_CORES-1:0] ack_mask_q;
    logic [N_CORES-1:0] core_ack_q, core_ack_d;
    logic [DATA_W-1:0]  core_data_q, core_data_d;
    logic [ADR_W-1:0]   core_adr_q, core_adr_d;
    logic               mem_req_q, mem_req_d;
    logic               mem_far_q, mem_far_d;
    logic [ADR_W-1:0]   mem_adr_q, mem_adr_d;

    logic [N_CORES-1:0] eligible;
    logic [N_CORES-1:0] coalesce_hit;
    logic [PTR_W-1:0]   pick_idx;
    logic               pick_valid;

    // A core may hold req for one cycle after its ack; masking last cycle's
    // acks keeps that trailing request from being granted a second time.
    assign eligible = node.core_req_i & ~ack_mask_q;

    always_comb begin
        int unsigned idx;
        pick_valid = 1'b0;
        pick_idx   = '0;
        idx        = 0;
        for (int i = 0; i < N_CORES; i++) begin
            idx = (int'(rr_ptr_q) + i) % N_CORES;
            if (!pick_valid && eligible[idx]) begin
                pick_valid = 1'b1;
                pick_idx   = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        coalesce_hit = '0;
        for (int j = 0; j < N_CORES; j++) begin
            coalesce_hit[j] = (COALESCE != 0) && eligible[j] &&
                              (node.core_adr_i[j*ADR_W +: ADR_W] == mem_adr_q);
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_idx_d = grant_idx_q;
        grant_d     = grant_q;
        core_ack_d  = '0;
        core_data_d = core_data_q;
        core_adr_d  = core_adr_q;
        mem_req_d   = mem_req_q;
        mem_far_d   = mem_far_q;
        mem_adr_d   = mem_adr_q;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_idx_d = pick_idx;
                    grant_d     = N_CORES'(1) << pick_idx;
                    mem_adr_d   = node.core_adr_i[pick_idx*ADR_W +: ADR_W];
                    mem_far_d   = node.core_far_i[pick_idx];
                    mem_req_d   = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (mem.mem_ack_i) begin
                    mem_req_d   = 1'b0;
                    core_data_d = mem.mem_data_i;
                    core_adr_d  = mem_adr_q;
                    // The granted core is acked even if it dropped its request.
                    core_ack_d  = grant_q | coalesce_hit;
                    rr_ptr_d    = (grant_idx_q == PTR_W'(N_CORES - 1)) ? '0
                                                                       : grant_idx_q + 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                grant_d = '0;
                state_d = IDLE;
            end
            default: begin
                grant_d   = '0;
                mem_req_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_idx_q <= '0;
            grant_q     <= '0;
            ack_mask_q  <= '0;
            core_ack_q  <= '0;
            core_data_q <= '0;
            core_adr_q  <= '0;
            mem_req_q   <= 1'b0;
            mem_far_q   <= 1'b0;
            mem_adr_q   <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_idx_q <= grant_idx_d;
            grant_q     <= grant_d;
            ack_mask_q  <= core_ack_q;
            core_ack_q  <= core_ack_d;
            core_data_q <= core_data_d;
            core_adr_q  <= core_adr_d;
            mem_req_q   <= mem_req_d;
            mem_far_q   <= mem_far_d;
            mem_adr_q   <= mem_adr_d;
        end
    end

    assign node.core_ack_o  = core_ack_q;
    assign node.core_data_o = core_data_q;
    assign node.core_adr_o  = core_adr_q;
    assign mem.mem_req_o    = mem_req_q;
    assign mem.mem_far_o    = mem_far_q;
    assign mem.mem_adr_o    = mem_adr_q;
    assign grant_o          = grant_q;
    assign state_o          = state_q;

endmodule

// File: tb/tb_raycast_node_arbiter.sv
// Directed bench for raycast_node_arbiter: one coalescing and one
// non-coalescing instance driven by the same core stimulus.
module tb_raycast_node_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- DUTs ----------------
    raycast_node_if #(.N_CORES(N), .ADR_W(AW), .DATA_W(DW)) nif1 ();
    raycast_node_if #(.N_CORES(N), .ADR_W(AW), .DATA_W(DW)) nif0 ();
    raycast_mem_if  #(.ADR_W(AW), .DATA_W(DW))              mif1 ();
    raycast_mem_if  #(.ADR_W(AW), .DATA_W(DW))              mif0 ();

    logic [N-1:0] grant1, grant0;
    logic [1:0]   st1, st0;

    raycast_node_arbiter #(.N_CORES(N), .ADR_W(AW), .DATA_W(DW), .COALESCE(1)) dut1 (
        .clk(clk), .rst(rst), .node(nif1.slave), .mem(mif1.master),
        .grant_o(grant1), .state_o(st1)
    );

    raycast_node_arbiter #(.N_CORES(N), .ADR_W(AW), .DATA_W(DW), .COALESCE(0)) dut0 (
        .clk(clk), .rst(rst), .node(nif0.slave), .mem(mif0.master),
        .grant_o(grant0), .state_o(st0)
    );

    // ---------------- stimulus state ----------------
    logic [N-1:0]    req1, req0, pend1, pend0;
    logic [N-1:0]    far_v, auto_drop, hold_extra;
    logic [N*AW-1:0] adr_v;
    logic            mack1, mack0;
    int              mcnt1, mcnt0;
    logic [DW-1:0]   mem_rdata;

    assign nif1.core_req_i = req1;
    assign nif1.core_far_i = far_v;
    assign nif1.core_adr_i = adr_v;
    assign nif0.core_req_i = req0;
    assign nif0.core_far_i = far_v;
    assign nif0.core_adr_i = adr_v;
    assign mif1.mem_ack_i  = mack1;
    assign mif1.mem_data_i = mem_rdata;
    assign mif0.mem_ack_i  = mack0;
    assign mif0.mem_data_i = mem_rdata;

    // ---------------- monitors / scoreboard ----------------
    int           cycle;
    logic         seen1, seen0;
    int           rises1, rises0;
    logic [N-1:0] grant_log1[$];
    int           rise_cyc1[$];
    logic [N-1:0] ack_log1[$];
    logic [N-1:0] ack_log0[$];
    logic [N-1:0] exp_q[$];

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic mem_step(input logic req, inout int cnt, inout logic ack);
        if (!rst || ack) begin
            cnt = 0;
            ack = 1'b0;
        end else if (req) begin
            cnt++;
            if (cnt == 2) ack = 1'b1;
        end
    endtask

    task automatic core_step(input logic [N-1:0] ack, inout logic [N-1:0] req,
                             inout logic [N-1:0] pend);
        for (int k = 0; k < N; k++) begin
            if (pend[k]) begin
                req[k]  = 1'b0;
                pend[k] = 1'b0;
            end else if (ack[k]) begin
                if (hold_extra[k]) pend[k] = 1'b1;
                else if (auto_drop[k]) req[k] = 1'b0;
            end
        end
    endtask

    // Advance to the next falling edge, then log and react like cores + memory.
    task automatic tick();
        @(negedge clk);
        cycle++;
        if (mif1.mem_req_o && !seen1) begin
            rises1++;
            grant_log1.push_back(grant1);
            rise_cyc1.push_back(cycle);
        end
        if (mif0.mem_req_o && !seen0) rises0++;
        seen1 = mif1.mem_req_o;
        seen0 = mif0.mem_req_o;
        if (nif1.core_ack_o != '0) ack_log1.push_back(nif1.core_ack_o);
        if (nif0.core_ack_o != '0) ack_log0.push_back(nif0.core_ack_o);
        mem_step(mif1.mem_req_o, mcnt1, mack1);
        mem_step(mif0.mem_req_o, mcnt0, mack0);
        core_step(nif1.core_ack_o, req1, pend1);
        core_step(nif0.core_ack_o, req0, pend0);
    endtask

    task automatic clear_logs();
        rises1 = 0;
        rises0 = 0;
        grant_log1.delete();
        rise_cyc1.delete();
        ack_log1.delete();
        ack_log0.delete();
    endtask

    task automatic do_reset();
        req1 = '0; req0 = '0; pend1 = '0; pend0 = '0;
        rst  = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        clear_logs();
    endtask

    task automatic settle(input int budget);
        int n;
        n = 0;
        while ((st1 != 2'd0 || st0 != 2'd0 || req1 != '0 || req0 != '0) && n < budget) begin
            tick();
            n++;
        end
        check("settle_done", 64'(n < budget), 64'd1);
        tick();
    endtask

    task automatic set_adr(input int k, input logic [AW-1:0] a);
        adr_v[k*AW +: AW] = a;
    endtask

    task automatic request(input logic [N-1:0] m);
        req1 = req1 | m;
        req0 = req0 | m;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int n;
        cycle = 0; seen1 = 1'b0; seen0 = 1'b0;
        far_v = '0; adr_v = '0; auto_drop = '1; hold_extra = '0;
        mack1 = 1'b0; mack0 = 1'b0; mcnt1 = 0; mcnt0 = 0;
        mem_rdata = '0;
        req1 = '0; req0 = '0; pend1 = '0; pend0 = '0;

        // Reset state
        tick();
        check("rst_mem_req",   64'(mif1.mem_req_o),   64'd0);
        check("rst_mem_far",   64'(mif1.mem_far_o),   64'd0);
        check("rst_mem_adr",   64'(mif1.mem_adr_o),   64'd0);
        check("rst_core_ack",  64'(nif1.core_ack_o),  64'd0);
        check("rst_core_data", 64'(nif1.core_data_o), 64'd0);
        check("rst_core_adr",  64'(nif1.core_adr_o),  64'd0);
        check("rst_grant",     64'(grant1),           64'd0);
        check("rst_state",     64'(st1),              64'd0);
        do_reset();

        // Single request from core 1
        mem_rdata = 32'hDEAD_BEEF;
        set_adr(1, 32'h100);
        request(4'b0010);
        tick();
        check("single_mem_req",  64'(mif1.mem_req_o), 64'd1);
        check("single_mem_adr",  64'(mif1.mem_adr_o), 64'h100);
        check("single_grant",    64'(grant1),         64'b0010);
        check("single_no_ack",   64'(nif1.core_ack_o), 64'd0);
        tick();
        check("single_hold_req", 64'(mif1.mem_req_o), 64'd1);
        tick();
        check("single_ack",      64'(nif1.core_ack_o),  64'b0010);
        check("single_data",     64'(nif1.core_data_o), 64'hDEAD_BEEF);
        check("single_rsp_adr",  64'(nif1.core_adr_o),  64'h100);
        check("single_resp_req", 64'(mif1.mem_req_o),   64'd0);
        tick();
        check("single_ack_clr",  64'(nif1.core_ack_o),  64'd0);
        check("single_data_hold", 64'(nif1.core_data_o), 64'hDEAD_BEEF);
        settle(20);

        // Far flag held for the whole ISSUE state
        mem_rdata = 32'h1234_5678;
        far_v[0]  = 1'b1;
        set_adr(0, 32'h200);
        request(4'b0001);
        tick();
        check("far_issue1", 64'(mif1.mem_far_o), 64'd1);
        check("far_adr",    64'(mif1.mem_adr_o), 64'h200);
        tick();
        check("far_issue2", 64'(mif1.mem_far_o), 64'd1);
        settle(20);
        far_v = '0;

        // Ack masking: core 2 keeps req one cycle past its ack
        clear_logs();
        hold_extra[2] = 1'b1;
        set_adr(2, 32'h300);
        request(4'b0100);
        for (int i = 0; i < 8; i++) tick();
        check("mask_one_read", 64'(rises1), 64'd1);
        check("mask_grant",    64'(grant1), 64'd0);
        check("mask_mem_req",  64'(mif1.mem_req_o), 64'd0);
        hold_extra = '0;
        settle(20);

        // Coalescing: cores 0 and 3 both want 0x40
        do_reset();
        set_adr(0, 32'h40);
        set_adr(3, 32'h40);
        request(4'b1001);
        settle(40);
        check("coal_reads_c1", 64'(rises1), 64'd1);
        check("coal_reads_c0", 64'(rises0), 64'd2);
        exp_q = '{4'b1001};
        check("coal_acks_c1", 64'(ack_log1.size()), 64'(exp_q.size()));
        while (exp_q.size() > 0 && ack_log1.size() > 0)
            check("coal_ack_c1", 64'(ack_log1.pop_front()), 64'(exp_q.pop_front()));
        exp_q = '{4'b0001, 4'b1000};
        check("coal_acks_c0", 64'(ack_log0.size()), 64'(exp_q.size()));
        while (exp_q.size() > 0 && ack_log0.size() > 0)
            check("coal_ack_c0", 64'(ack_log0.pop_front()), 64'(exp_q.pop_front()));

        // Round robin: cores 0, 2, 3 request continuously at distinct addresses
        do_reset();
        auto_drop = '0;
        set_adr(0, 32'h10);
        set_adr(2, 32'h30);
        set_adr(3, 32'h50);
        request(4'b1101);
        n = 0;
        while (grant_log1.size() < 6 && n < 60) begin
            tick();
            n++;
        end
        req1 = '0;
        req0 = '0;
        auto_drop = '1;
        settle(20);
        exp_q = '{4'b0001, 4'b0100, 4'b1000, 4'b0001, 4'b0100, 4'b1000};
        check("rr_count", 64'(grant_log1.size() >= 6), 64'd1);
        while (exp_q.size() > 0 && grant_log1.size() > 0)
            check("rr_grant", 64'(grant_log1.pop_front()), 64'(exp_q.pop_front()));
        if (rise_cyc1.size() >= 3) begin
            check("rr_spacing1", 64'(rise_cyc1[1] - rise_cyc1[0]), 64'd4);
            check("rr_spacing2", 64'(rise_cyc1[2] - rise_cyc1[1]), 64'd4);
        end

        // Reset during ISSUE; rr_ptr must restart at 0
        set_adr(1, 32'h500);
        request(4'b0010);
        settle(20);
        set_adr(2, 32'h600);
        request(4'b0100);
        tick();
        check("midrst_pre_req", 64'(mif1.mem_req_o), 64'd1);
        req1 = '0; req0 = '0; pend1 = '0; pend0 = '0;
        rst  = 1'b0;
        #1;
        check("midrst_mem_req",  64'(mif1.mem_req_o),  64'd0);
        check("midrst_grant",    64'(grant1),          64'd0);
        check("midrst_core_ack", 64'(nif1.core_ack_o), 64'd0);
        check("midrst_state",    64'(st1),             64'd0);
        tick();
        tick();
        rst = 1'b1;
        set_adr(3, 32'h700);
        request(4'b1010);
        tick();
        check("midrst_first_grant", 64'(grant1),         64'b0010);
        check("midrst_first_adr",   64'(mif1.mem_adr_o), 64'h500);
        settle(40);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
